assoc_cache: RTL and testbench

- Parametrised N-way set-associative cache; next generation of the fixed direct-mapped cache between pipelined datapath and instruction/data memory.
- Configurable line size, sets, ways, memory latency, write policy (write-back or write-through, both write-allocate), true-LRU replacement, hit/miss statistics.
- Instantiated twice per CPU: I-side with write tied 0, and D-side.

---
 rtl/cache_pkg.sv | 30 +++
 rtl/cache_lru.sv | 54 +++++
 rtl/assoc_cache.sv | 229 ++++++++++++++++++++++
 tb/tb_assoc_cache.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types and address-field width helpers for assoc_cache
package cache_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EVICT,
    S_FILL,
    S_WT_WRITE
  } state_t;

  localparam int CNT_W = 16;

  // Storage widths never drop below 1 so single-set/single-way builds still elaborate.
  function automatic int width_min1(input int n);
    return (n < 1) ? 1 : n;
  endfunction

  function automatic int off_bits(input int words_per_line);
    return $clog2(words_per_line);
  endfunction

  function automatic int idx_bits(input int num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int tag_bits(input int word_size, input int words_per_line, input int num_sets);
    return word_size - $clog2(words_per_line) - $clog2(num_sets);
  endfunction

endpackage

// File: rtl/cache_lru.sv
// rtl/cache_lru.sv - per-set true-LRU age table; reports the oldest way of the addressed set
module cache_lru
  import cache_pkg::*;
#(
  parameter int NUM_SETS = 4,
  parameter int NUM_WAYS = 2,
  parameter int IDX_SW   = 2,
  parameter int WAY_W    = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [IDX_SW-1:0] index,
  input  logic [WAY_W-1:0]  acc_way,
  input  logic              acc_en,
  output logic [WAY_W-1:0]  victim
);

  localparam int AGE_W = width_min1($clog2(NUM_WAYS));
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(NUM_WAYS - 1);

  logic [AGE_W-1:0] age_q [NUM_SETS][NUM_WAYS];
  logic [AGE_W-1:0] acc_age;
  logic [AGE_W-1:0] best;

  assign acc_age = age_q[index][acc_way];

  // Ways no older than the accessed one age by one; ties after reset resolve themselves.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < NUM_SETS; s++)
        for (int w = 0; w < NUM_WAYS; w++)
          age_q[s][w] <= '0;
    end else if (acc_en) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (WAY_W'(w) == acc_way)
          age_q[index][w] <= '0;
        else if (age_q[index][w] <= acc_age && age_q[index][w] != AGE_MAX)
          age_q[index][w] <= age_q[index][w] + AGE_W'(1);
      end
    end
  end

  always_comb begin
    victim = '0;
    best   = age_q[index][0];
    for (int w = 1; w < NUM_WAYS; w++) begin
      if (age_q[index][w] > best) begin
        best   = age_q[index][w];
        victim = WAY_W'(w);
      end
    end
  end

endmodule

// File: rtl/assoc_cache.sv
// rtl/assoc_cache.sv - N-way set-associative write-allocate cache, write-back or write-through
module assoc_cache
  import cache_pkg::*;
#(
  parameter int WORD_SIZE      = 16,
  parameter int WORDS_PER_LINE = 4,
  parameter int NUM_SETS       = 4,
  parameter int NUM_WAYS       = 2,
  parameter int MEM_LATENCY    = 2,
  parameter int WRITE_BACK     = 1
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                read_cache,
  input  logic                                write_cache,
  input  logic [WORD_SIZE-1:0]                address_cache,
  input  logic [WORD_SIZE-1:0]                wdata,
  output logic [WORD_SIZE-1:0]                rdata,
  output logic                                cache_ready,
  output logic                                done_write,
  output logic [WORD_SIZE-1:0]                address_memory,
  output logic                                readM,
  output logic                                writeM,
  output logic [WORDS_PER_LINE*WORD_SIZE-1:0] mem_wdata,
  input  logic [WORDS_PER_LINE*WORD_SIZE-1:0] mem_rdata,
  output logic [CNT_W-1:0]                    hit_count,
  output logic [CNT_W-1:0]                    miss_count
);

  localparam int OFF_W  = off_bits(WORDS_PER_LINE);
  localparam int IDX_W  = idx_bits(NUM_SETS);
  localparam int IDX_SW = width_min1(IDX_W);
  localparam int TAG_W  = tag_bits(WORD_SIZE, WORDS_PER_LINE, NUM_SETS);
  localparam int WAY_W  = width_min1($clog2(NUM_WAYS));
  localparam int LINE_W = WORDS_PER_LINE * WORD_SIZE;
  localparam int LAT_W  = width_min1($clog2(MEM_LATENCY + 1));

  logic [LINE_W-1:0]   data_q  [NUM_SETS][NUM_WAYS];
  logic [TAG_W-1:0]    tag_q   [NUM_SETS][NUM_WAYS];
  logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0] dirty_q [NUM_SETS];

  state_t            state_q;
  logic [LAT_W-1:0]  cnt_q;
  logic [IDX_SW-1:0] req_idx_q;
  logic [TAG_W-1:0]  req_tag_q;
  logic [WAY_W-1:0]  req_way_q;
  logic              refill_q;

  logic [OFF_W-1:0]  offset;
  logic [IDX_SW-1:0] index;
  logic [TAG_W-1:0]  tag;
  logic              hit, free_found;
  logic [WAY_W-1:0]  hit_way, free_way, lru_victim, victim_way;
  logic [LINE_W-1:0] hit_line;
  logic [WORD_SIZE-1:0] rd_word;
  logic              req, idle, idle_hit, idle_miss, last;
  logic [IDX_SW-1:0] lru_index;
  logic [WAY_W-1:0]  lru_way;
  logic              lru_en;

  function automatic logic [WORD_SIZE-1:0] line_addr(input logic [TAG_W-1:0] t,
                                                     input logic [IDX_SW-1:0] i);
    return (WORD_SIZE'(t) << (OFF_W + IDX_W)) | (WORD_SIZE'(i) << OFF_W);
  endfunction

  assign offset = address_cache[OFF_W-1:0];
  assign index  = IDX_SW'((address_cache >> OFF_W) & WORD_SIZE'(NUM_SETS - 1));
  assign tag    = TAG_W'(address_cache >> (OFF_W + IDX_W));

  always_comb begin
    hit        = 1'b0;
    hit_way    = '0;
    free_found = 1'b0;
    free_way   = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!hit && valid_q[index][w] && tag_q[index][w] == tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!free_found && !valid_q[index][w]) begin
        free_found = 1'b1;
        free_way   = WAY_W'(w);
      end
    end
  end

  assign victim_way = free_found ? free_way : lru_victim;
  assign hit_line   = data_q[index][hit_way];
  assign rd_word    = hit_line[int'(offset)*WORD_SIZE +: WORD_SIZE];

  assign req       = read_cache | write_cache;
  assign idle      = (state_q == S_IDLE);
  assign idle_hit  = idle && req && hit;
  assign idle_miss = idle && req && !hit;
  assign last      = (cnt_q == LAT_W'(MEM_LATENCY - 1));

  // Write-through writes only complete once the line has reached memory.
  assign cache_ready = (idle_hit && (!write_cache || WRITE_BACK != 0)) ||
                       (state_q == S_WT_WRITE && last && write_cache);
  assign done_write  = cache_ready && write_cache;
  assign rdata       = (idle_hit && !write_cache) ? rd_word : '0;
  assign readM       = (state_q == S_FILL);
  assign writeM      = (state_q == S_EVICT) || (state_q == S_WT_WRITE);

  always_comb begin
    address_memory = '0;
    mem_wdata      = '0;
    case (state_q)
      S_EVICT: begin
        address_memory = line_addr(tag_q[req_idx_q][req_way_q], req_idx_q);
        mem_wdata      = data_q[req_idx_q][req_way_q];
      end
      S_FILL: address_memory = line_addr(req_tag_q, req_idx_q);
      S_WT_WRITE: begin
        address_memory = line_addr(req_tag_q, req_idx_q);
        mem_wdata      = data_q[req_idx_q][req_way_q];
      end
      default: ;
    endcase
  end

  // The refilled way becomes MRU at fill time; the re-evaluated hit must not touch LRU again.
  assign lru_index = (state_q == S_FILL) ? req_idx_q : index;
  assign lru_way   = (state_q == S_FILL) ? req_way_q : hit_way;
  assign lru_en    = (idle_hit && !refill_q) || (state_q == S_FILL && last);

  cache_lru #(
    .NUM_SETS (NUM_SETS),
    .NUM_WAYS (NUM_WAYS),
    .IDX_SW   (IDX_SW),
    .WAY_W    (WAY_W)
  ) u_lru (
    .clk     (clk),
    .reset_n (reset_n),
    .index   (lru_index),
    .acc_way (lru_way),
    .acc_en  (lru_en),
    .victim  (lru_victim)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      req_idx_q  <= '0;
      req_tag_q  <= '0;
      req_way_q  <= '0;
      refill_q   <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
      end
    end else begin
      refill_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (idle_hit) begin
            if (!refill_q && hit_count != '1)
              hit_count <= hit_count + 1'b1;
            if (write_cache) begin
              if (WRITE_BACK != 0) begin
                dirty_q[index][hit_way] <= 1'b1;
              end else begin
                req_idx_q <= index;
                req_tag_q <= tag;
                req_way_q <= hit_way;
                state_q   <= S_WT_WRITE;
              end
            end
          end else if (idle_miss) begin
            if (miss_count != '1)
              miss_count <= miss_count + 1'b1;
            req_idx_q <= index;
            req_tag_q <= tag;
            req_way_q <= victim_way;
            if (WRITE_BACK != 0 && valid_q[index][victim_way] && dirty_q[index][victim_way])
              state_q <= S_EVICT;
            else
              state_q <= S_FILL;
          end
        end
        S_EVICT: begin
          if (last) begin
            cnt_q                         <= '0;
            dirty_q[req_idx_q][req_way_q] <= 1'b0;
            state_q                       <= S_FILL;
          end else begin
            cnt_q <= cnt_q + LAT_W'(1);
          end
        end
        S_FILL: begin
          if (last) begin
            cnt_q                         <= '0;
            valid_q[req_idx_q][req_way_q] <= 1'b1;
            dirty_q[req_idx_q][req_way_q] <= 1'b0;
            refill_q                      <= 1'b1;
            state_q                       <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + LAT_W'(1);
          end
        end
        S_WT_WRITE: begin
          if (last) begin
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + LAT_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Line payload and tags need no reset: valid bits gate every use.
  always_ff @(posedge clk) begin
    if (idle_hit && write_cache)
      data_q[index][hit_way][int'(offset)*WORD_SIZE +: WORD_SIZE] <= wdata;
    if (state_q == S_FILL && last) begin
      data_q[req_idx_q][req_way_q] <= mem_rdata;
      tag_q[req_idx_q][req_way_q]  <= req_tag_q;
    end
  end

endmodule

// File: tb/tb_assoc_cache.sv
// tb/tb_assoc_cache.sv - directed bench for assoc_cache (write-back and write-through instances)
module tb_assoc_cache;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rd_c [2];
  logic        wr_c [2];
  logic [15:0] addr_c [2];
  logic [15:0] wd_c [2];
  logic [15:0] rdata_o [2];
  logic [15:0] amem_o [2];
  logic [15:0] hit_o [2];
  logic [15:0] miss_o [2];
  logic        ready_o [2];
  logic        dw_o [2];
  logic        readm_o [2];
  logic        writem_o [2];
  logic [63:0] mwd_o [2];
  logic [63:0] mrd_i [2];

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  // Backing memory: word at address a holds a*3.
  function automatic logic [63:0] mem_line(input logic [15:0] a);
    logic [63:0] l;
    for (int i = 0; i < 4; i++) l[i*16 +: 16] = (a + 16'(i)) * 16'd3;
    return l;
  endfunction

  assign mrd_i[0] = mem_line(amem_o[0]);
  assign mrd_i[1] = mem_line(amem_o[1]);

  assoc_cache #(.WRITE_BACK(1)) dut_wb (
    .clk(clk), .reset_n(reset_n), .read_cache(rd_c[0]), .write_cache(wr_c[0]),
    .address_cache(addr_c[0]), .wdata(wd_c[0]), .rdata(rdata_o[0]), .cache_ready(ready_o[0]),
    .done_write(dw_o[0]), .address_memory(amem_o[0]), .readM(readm_o[0]), .writeM(writem_o[0]),
    .mem_wdata(mwd_o[0]), .mem_rdata(mrd_i[0]), .hit_count(hit_o[0]), .miss_count(miss_o[0])
  );

  assoc_cache #(.WRITE_BACK(0)) dut_wt (
    .clk(clk), .reset_n(reset_n), .read_cache(rd_c[1]), .write_cache(wr_c[1]),
    .address_cache(addr_c[1]), .wdata(wd_c[1]), .rdata(rdata_o[1]), .cache_ready(ready_o[1]),
    .done_write(dw_o[1]), .address_memory(amem_o[1]), .readM(readm_o[1]), .writeM(writem_o[1]),
    .mem_wdata(mwd_o[1]), .mem_rdata(mrd_i[1]), .hit_count(hit_o[1]), .miss_count(miss_o[1])
  );

  // Issues one request at posedge+1 and records per-cycle memory activity until cache_ready.
  task automatic do_req(input int d, input logic wr, input logic [15:0] a, input logic [15:0] data,
                        output int rdy, output logic [15:0] rd, output logic dw,
                        output logic [31:0] rm, output logic [31:0] wm, output logic [63:0] line,
                        output logic [15:0] ev_addr, output logic [15:0] fl_addr);
    rdy = -1; rd = '0; dw = 1'b0; rm = '0; wm = '0; line = '0; ev_addr = '0; fl_addr = '0;
    rd_c[d] = !wr; wr_c[d] = wr; addr_c[d] = a; wd_c[d] = data;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      if (readm_o[d]) begin
        if (rm == 0) fl_addr = amem_o[d];
        rm[c] = 1'b1;
      end
      if (writem_o[d]) begin
        if (wm == 0) ev_addr = amem_o[d];
        wm[c] = 1'b1;
        line = mwd_o[d];
      end
      if (ready_o[d]) begin
        rdy = c; rd = rdata_o[d]; dw = dw_o[d];
        break;
      end
    end
    @(posedge clk); #1;
    rd_c[d] = 1'b0; wr_c[d] = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      total_cnt++; if (ready_o[d] !== 1'b0) $display("FAIL reset_ready[%0d]: got %b want 0", d, ready_o[d]); else pass_cnt++;
      total_cnt++; if ({readm_o[d], writem_o[d]} !== 2'b00) $display("FAIL reset_mem[%0d]: got %b want 00", d, {readm_o[d], writem_o[d]}); else pass_cnt++;
      total_cnt++; if ({hit_o[d], miss_o[d]} !== 32'h0) $display("FAIL reset_counters[%0d]: got %h want 0", d, {hit_o[d], miss_o[d]}); else pass_cnt++;
      total_cnt++; if (rdata_o[d] !== 16'h0) $display("FAIL reset_rdata[%0d]: got %h want 0", d, rdata_o[d]); else pass_cnt++;
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_cold_read;
    int rdy; logic [15:0] rd, ea, fa; logic dw; logic [31:0] rm, wm; logic [63:0] ln;
    do_req(0, 1'b0, 16'h0005, 16'h0, rdy, rd, dw, rm, wm, ln, ea, fa);
    total_cnt++; if (rdy !== 3) $display("FAIL cold_ready_cycle: got %0d want 3", rdy); else pass_cnt++;
    total_cnt++; if (rm !== 32'h6) $display("FAIL cold_readM_cycles: got %h want 6", rm); else pass_cnt++;
    total_cnt++; if (fa !== 16'h0004) $display("FAIL cold_mem_addr: got %h want 0004", fa); else pass_cnt++;
    total_cnt++; if (rd !== 16'h000F) $display("FAIL cold_rdata: got %h want 000f", rd); else pass_cnt++;
    total_cnt++; if (miss_o[0] !== 16'd1 || hit_o[0] !== 16'd0) $display("FAIL cold_counters: got hit %0d miss %0d want 0/1", hit_o[0], miss_o[0]); else pass_cnt++;
  endtask

  task automatic test_hit_read;
    int rdy; logic [15:0] rd, ea, fa; logic dw; logic [31:0] rm, wm; logic [63:0] ln;
    @(posedge clk); #1;
    do_req(0, 1'b0, 16'h0006, 16'h0, rdy, rd, dw, rm, wm, ln, ea, fa);
    total_cnt++; if (rdy !== 0) $display("FAIL hit_ready_cycle: got %0d want 0", rdy); else pass_cnt++;
    total_cnt++; if (rd !== 16'h0012) $display("FAIL hit_rdata: got %h want 0012", rd); else pass_cnt++;
    total_cnt++; if (rm !== 32'h0) $display("FAIL hit_no_readM: got %h want 0", rm); else pass_cnt++;
    total_cnt++; if (hit_o[0] !== 16'd1) $display("FAIL hit_count: got %0d want 1", hit_o[0]); else pass_cnt++;
  endtask

  task automatic test_wb_evict;
    int rdy; logic [15:0] rd, ea, fa; logic dw; logic [31:0] rm, wm; logic [63:0] ln;
    @(posedge clk); #1;
    do_req(0, 1'b1, 16'h0004, 16'hBEEF, rdy, rd, dw, rm, wm, ln, ea, fa);
    total_cnt++; if (rdy !== 0 || dw !== 1'b1 || wm !== 32'h0) $display("FAIL wb_write_hit: got rdy %0d dw %b wm %h want 0/1/0", rdy, dw, wm); else pass_cnt++;
    @(posedge clk); #1;
    do_req(0, 1'b0, 16'h0014, 16'h0, rdy, rd, dw, rm, wm, ln, ea, fa);
    total_cnt++; if (rdy !== 3 || wm !== 32'h0 || rd !== 16'h003C) $display("FAIL wb_clean_fill: got rdy %0d wm %h rd %h want 3/0/003c", rdy, wm, rd); else pass_cnt++;
    @(posedge clk); #1;
    do_req(0, 1'b0, 16'h0024, 16'h0, rdy, rd, dw, rm, wm, ln, ea, fa);
    total_cnt++; if (wm !== 32'h6) $display("FAIL evict_writeM_cycles: got %h want 6", wm); else pass_cnt++;
    total_cnt++; if (ea !== 16'h0004) $display("FAIL evict_addr: got %h want 0004", ea); else pass_cnt++;
    total_cnt++; if (ln !== 64'h0015_0012_000F_BEEF) $display("FAIL evict_line: got %h want 00150012000fbeef", ln); else pass_cnt++;
    total_cnt++; if (rm !== 32'h18 || fa !== 16'h0024) $display("FAIL evict_fill: got rm %h addr %h want 18/0024", rm, fa); else pass_cnt++;
    total_cnt++; if (rdy !== 5 || rd !== 16'h006C) $display("FAIL evict_ready: got rdy %0d rd %h want 5/006c", rdy, rd); else pass_cnt++;
    total_cnt++; if (miss_o[0] !== 16'd3 || hit_o[0] !== 16'd2) $display("FAIL evict_counters: got hit %0d miss %0d want 2/3", hit_o[0], miss_o[0]); else pass_cnt++;
  endtask

  task automatic test_lru;
    int rdy; logic [15:0] rd, ea, fa; logic dw; logic [31:0] rm, wm; logic [63:0] ln;
    @(posedge clk); #1; do_req(0, 1'b0, 16'h0000, 16'h0, rdy, rd, dw, rm, wm, ln, ea, fa);
    @(posedge clk); #1; do_req(0, 1'b0, 16'h0010, 16'h0, rdy, rd, dw, rm, wm, ln, ea, fa);
    @(posedge clk); #1; do_req(0, 1'b0, 16'h0001, 16'h0, rdy, rd, dw, rm, wm, ln, ea, fa);
    total_cnt++; if (rdy !== 0 || rd !== 16'h0003) $display("FAIL lru_touch: got rdy %0d rd %h want 0/0003", rdy, rd); else pass_cnt++;
    @(posedge clk); #1; do_req(0, 1'b0, 16'h0020, 16'h0, rdy, rd, dw, rm, wm, ln, ea, fa);
    total_cnt++; if (rdy !== 3 || rd !== 16'h0060) $display("FAIL lru_replace: got rdy %0d rd %h want 3/0060", rdy, rd); else pass_cnt++;
    @(posedge clk); #1; do_req(0, 1'b0, 16'h0001, 16'h0, rdy, rd, dw, rm, wm, ln, ea, fa);
    total_cnt++; if (rdy !== 0 || rd !== 16'h0003) $display("FAIL lru_mru_kept: got rdy %0d rd %h want 0/0003", rdy, rd); else pass_cnt++;
    @(posedge clk); #1; do_req(0, 1'b0, 16'h0010, 16'h0, rdy, rd, dw, rm, wm, ln, ea, fa);
    total_cnt++; if (rdy !== 3 || rd !== 16'h0030) $display("FAIL lru_victim_gone: got rdy %0d rd %h want 3/0030", rdy, rd); else pass_cnt++;
    total_cnt++; if (hit_o[0] !== 16'd4 || miss_o[0] !== 16'd7) $display("FAIL lru_counters: got hit %0d miss %0d want 4/7", hit_o[0], miss_o[0]); else pass_cnt++;
  endtask

  task automatic test_write_through;
    int rdy; logic [15:0] rd, ea, fa; logic dw; logic [31:0] rm, wm; logic [63:0] ln;
    @(posedge clk); #1; do_req(1, 1'b0, 16'h0006, 16'h0, rdy, rd, dw, rm, wm, ln, ea, fa);
    total_cnt++; if (rdy !== 3 || rd !== 16'h0012) $display("FAIL wt_cold_read: got rdy %0d rd %h want 3/0012", rdy, rd); else pass_cnt++;
    @(posedge clk); #1; do_req(1, 1'b1, 16'h0006, 16'h1234, rdy, rd, dw, rm, wm, ln, ea, fa);
    total_cnt++; if (wm !== 32'h6 || ea !== 16'h0004) $display("FAIL wt_writeM: got wm %h addr %h want 6/0004", wm, ea); else pass_cnt++;
    total_cnt++; if (rdy !== 2 || dw !== 1'b1) $display("FAIL wt_done_write: got rdy %0d dw %b want 2/1", rdy, dw); else pass_cnt++;
    total_cnt++; if (ln !== 64'h0015_1234_000F_000C) $display("FAIL wt_line: got %h want 00151234000f000c", ln); else pass_cnt++;
    @(posedge clk); #1; do_req(1, 1'b0, 16'h0006, 16'h0, rdy, rd, dw, rm, wm, ln, ea, fa);
    total_cnt++; if (rdy !== 0 || rd !== 16'h1234) $display("FAIL wt_readback: got rdy %0d rd %h want 0/1234", rdy, rd); else pass_cnt++;
    @(posedge clk); #1; do_req(1, 1'b1, 16'h0040, 16'hAAAA, rdy, rd, dw, rm, wm, ln, ea, fa);
    total_cnt++; if (rdy !== 5 || rm !== 32'h6 || wm !== 32'h30) $display("FAIL wt_write_miss: got rdy %0d rm %h wm %h want 5/6/30", rdy, rm, wm); else pass_cnt++;
    total_cnt++; if (ln !== 64'h00C9_00C6_00C3_AAAA) $display("FAIL wt_miss_line: got %h want 00c900c600c3aaaa", ln); else pass_cnt++;
    total_cnt++; if (hit_o[1] !== 16'd2 || miss_o[1] !== 16'd2) $display("FAIL wt_counters: got hit %0d miss %0d want 2/2", hit_o[1], miss_o[1]); else pass_cnt++;
  endtask

  task automatic test_reset_mid_fill;
    int rdy; logic [15:0] rd, ea, fa; logic dw; logic [31:0] rm, wm; logic [63:0] ln;
    @(posedge clk); #1;
    rd_c[0] = 1'b1; addr_c[0] = 16'h0030;
    @(negedge clk);
    @(negedge clk);
    total_cnt++; if (readm_o[0] !== 1'b1) $display("FAIL midfill_started: got %b want 1", readm_o[0]); else pass_cnt++;
    reset_n = 1'b0;
    #1;
    total_cnt++; if (readm_o[0] !== 1'b0) $display("FAIL midfill_readM_drop: got %b want 0", readm_o[0]); else pass_cnt++;
    total_cnt++; if (hit_o[0] !== 16'd0 || miss_o[0] !== 16'd0) $display("FAIL midfill_counters: got hit %0d miss %0d want 0/0", hit_o[0], miss_o[0]); else pass_cnt++;
    rd_c[0] = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    do_req(0, 1'b0, 16'h0030, 16'h0, rdy, rd, dw, rm, wm, ln, ea, fa);
    total_cnt++; if (rdy !== 3 || rm !== 32'h6 || rd !== 16'h0090) $display("FAIL midfill_remiss: got rdy %0d rm %h rd %h want 3/6/0090", rdy, rm, rd); else pass_cnt++;
    total_cnt++; if (miss_o[0] !== 16'd1) $display("FAIL midfill_miss_count: got %0d want 1", miss_o[0]); else pass_cnt++;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rd_c[d] = 1'b0; wr_c[d] = 1'b0; addr_c[d] = '0; wd_c[d] = '0;
    end
    repeat (2) @(posedge clk);
    test_reset();
    test_cold_read();
    test_hit_read();
    test_wb_evict();
    test_lru();
    test_write_through();
    test_reset_mid_fill();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
